// File: rtl/maze_renderer.sv
// maze_renderer: scans a VGA raster and draws walls, dots and the player sprite as RGB444 with hsync/vsync.
// Optional build macro MAZE_GRID_EN adds a 222 debug grid on the top/left edge of every road tile.
`timescale 1ns/1ps
module maze_renderer #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int TILE   = 20,
    parameter int SPRITE = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [767:0] tilemap,
    input  logic [767:0] dots,
    input  logic [9:0]   player_x,
    input  logic [8:0]   player_y,
    output logic         hsync,
    output logic         vsync,
    output logic [11:0]  rgb,
    output logic         frame_tick
);

    localparam logic [9:0]  H_LAST    = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]  H_VIS_W   = 10'(H_VIS);
    localparam logic [9:0]  V_VIS_W   = 10'(V_VIS);
    localparam logic [9:0]  HS_START  = 10'(H_VIS + H_FP);
    localparam logic [9:0]  HS_END    = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0]  VS_START  = 10'(V_VIS + V_FP);
    localparam logic [9:0]  VS_END    = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [4:0]  TILE_LAST = 5'(TILE - 1);
    localparam logic [10:0] SPRITE_W  = 11'(SPRITE);

    // S0: raster and tile counters
    logic [9:0] hcount_q, hcount_d;
    logic [9:0] vcount_q, vcount_d;
    logic [4:0] sub_x_q, sub_x_d;
    logic [5:0] tile_col_q, tile_col_d;
    logic [4:0] sub_y_q, sub_y_d;
    logic [4:0] tile_row_q, tile_row_d;
    logic [9:0] snap_x_q, snap_x_d;
    logic [8:0] snap_y_q, snap_y_d;

    // S1: per-pixel attributes
    logic wall_q, wall_d;
    logic dot_q, dot_d;
    logic in_sprite_q, in_sprite_d;
    logic dot_ctr_q, dot_ctr_d;
    logic visible_q, visible_d;
    logic hsync_raw_q, hsync_raw_d;
    logic vsync_raw_q, vsync_raw_d;
`ifdef MAZE_GRID_EN
    logic grid_q, grid_d;
`endif

    // S2: outputs
    logic [11:0] rgb_q, rgb_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        frame_tick_q, frame_tick_d;

    logic        h_last, v_last, snap_point, tile_ok;
    logic [9:0]  tile_idx;
    logic [10:0] hx, vy, sx, sy;

    always_comb begin
        h_last     = (hcount_q == H_LAST);
        v_last     = (vcount_q == V_LAST);
        snap_point = (hcount_q == 10'd0) && (vcount_q == V_VIS_W);

        hcount_d = h_last ? 10'd0 : hcount_q + 10'd1;
        vcount_d = vcount_q;
        if (h_last) begin
            vcount_d = v_last ? 10'd0 : vcount_q + 10'd1;
        end

        sub_x_d    = sub_x_q + 5'd1;
        tile_col_d = tile_col_q;
        if (h_last) begin
            sub_x_d    = 5'd0;
            tile_col_d = 6'd0;
        end else if (sub_x_q == TILE_LAST) begin
            sub_x_d    = 5'd0;
            tile_col_d = tile_col_q + 6'd1;
        end

        sub_y_d    = sub_y_q;
        tile_row_d = tile_row_q;
        if (h_last) begin
            if (v_last) begin
                sub_y_d    = 5'd0;
                tile_row_d = 5'd0;
            end else if (vcount_q < V_VIS_W) begin
                if (sub_y_q == TILE_LAST) begin
                    sub_y_d    = 5'd0;
                    tile_row_d = tile_row_q + 5'd1;
                end else begin
                    sub_y_d = sub_y_q + 5'd1;
                end
            end
        end

        // Sprite position only changes at the start of vertical blank so a frame never tears
        snap_x_d     = snap_point ? player_x : snap_x_q;
        snap_y_d     = snap_point ? player_y : snap_y_q;
        frame_tick_d = snap_point;

        // Off-map tiles (blanking columns/rows) read index 0; the visible flag masks them anyway
        tile_ok  = (tile_row_q < 5'd24) && (tile_col_q < 6'd32);
        tile_idx = tile_ok ? {tile_row_q, tile_col_q[4:0]} : 10'd0;
        wall_d   = ~tilemap[tile_idx];
        dot_d    = dots[tile_idx];

        // 11-bit compare so a sprite near the right/bottom edge never wraps to column/row 0
        hx          = {1'b0, hcount_q};
        vy          = {1'b0, vcount_q};
        sx          = {1'b0, snap_x_q};
        sy          = {2'b00, snap_y_q};
        in_sprite_d = (hx >= sx) && (hx < sx + SPRITE_W) && (vy >= sy) && (vy < sy + SPRITE_W);

        dot_ctr_d   = (sub_x_q >= 5'd8) && (sub_x_q <= 5'd11) &&
                      (sub_y_q >= 5'd8) && (sub_y_q <= 5'd11);
        visible_d   = (hcount_q < H_VIS_W) && (vcount_q < V_VIS_W);
        hsync_raw_d = !((hcount_q >= HS_START) && (hcount_q <= HS_END));
        vsync_raw_d = !((vcount_q >= VS_START) && (vcount_q <= VS_END));
`ifdef MAZE_GRID_EN
        grid_d      = (sub_x_q == 5'd0) || (sub_y_q == 5'd0);
`endif

        rgb_d = 12'h000;
        if (!visible_q) begin
            rgb_d = 12'h000;
        end else if (in_sprite_q) begin
            rgb_d = 12'hFF0;
        end else if (wall_q) begin
            rgb_d = 12'h00F;
        end else if (dot_q && dot_ctr_q) begin
            rgb_d = 12'hFFF;
`ifdef MAZE_GRID_EN
        end else if (grid_q) begin
            rgb_d = 12'h222;
`endif
        end
        hsync_d = hsync_raw_q;
        vsync_d = vsync_raw_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcount_q     <= 10'd0;
            vcount_q     <= 10'd0;
            sub_x_q      <= 5'd0;
            tile_col_q   <= 6'd0;
            sub_y_q      <= 5'd0;
            tile_row_q   <= 5'd0;
            snap_x_q     <= 10'd0;
            snap_y_q     <= 9'd0;
            wall_q       <= 1'b0;
            dot_q        <= 1'b0;
            in_sprite_q  <= 1'b0;
            dot_ctr_q    <= 1'b0;
            visible_q    <= 1'b0;
            hsync_raw_q  <= 1'b1;
            vsync_raw_q  <= 1'b1;
`ifdef MAZE_GRID_EN
            grid_q       <= 1'b0;
`endif
            rgb_q        <= 12'h000;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            hcount_q     <= hcount_d;
            vcount_q     <= vcount_d;
            sub_x_q      <= sub_x_d;
            tile_col_q   <= tile_col_d;
            sub_y_q      <= sub_y_d;
            tile_row_q   <= tile_row_d;
            snap_x_q     <= snap_x_d;
            snap_y_q     <= snap_y_d;
            wall_q       <= wall_d;
            dot_q        <= dot_d;
            in_sprite_q  <= in_sprite_d;
            dot_ctr_q    <= dot_ctr_d;
            visible_q    <= visible_d;
            hsync_raw_q  <= hsync_raw_d;
            vsync_raw_q  <= vsync_raw_d;
`ifdef MAZE_GRID_EN
            grid_q       <= grid_d;
`endif
            rgb_q        <= rgb_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign rgb        = rgb_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_maze_renderer.sv
// Bench for maze_renderer: a full-size instance checks horizontal timing; a shrunken-raster
// instance (80x60 visible, short porches) keeps whole frames short for pixel, snapshot and tick checks.
`timescale 1ns/1ps
module tb_maze_renderer;

    localparam int HT = 96;        // 80 + 4 + 8 + 4
    localparam int VT = 66;        // 60 + 2 + 2 + 2
    localparam int FT = HT * VT;   // 6336 clk per small frame
`ifdef MAZE_GRID_EN
    localparam logic [11:0] GRID_RGB = 12'h222;
`else
    localparam logic [11:0] GRID_RGB = 12'h000;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [767:0] tilemap;
    logic [767:0] dots;
    logic [9:0]   player_x;
    logic [8:0]   player_y;
    logic         hsync_s, vsync_s, tick_s;
    logic [11:0]  rgb_s;
    logic         hsync_f, vsync_f, tick_f;
    logic [11:0]  rgb_f;

    int cyc;
    int checks   = 0;
    int failures = 0;

    always #20 clk = ~clk;

    // cyc = number of rising edges since reset release; rgb after edge n shows raster pixel n-2
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    maze_renderer #(
        .H_VIS(80), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_VIS(60), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .TILE(20), .SPRITE(20)
    ) dut (
        .clk(clk), .reset(reset), .tilemap(tilemap), .dots(dots),
        .player_x(player_x), .player_y(player_y),
        .hsync(hsync_s), .vsync(vsync_s), .rgb(rgb_s), .frame_tick(tick_s)
    );

    maze_renderer dut_f (
        .clk(clk), .reset(reset), .tilemap(tilemap), .dots(dots),
        .player_x(player_x), .player_y(player_y),
        .hsync(hsync_f), .vsync(vsync_f), .rgb(rgb_f), .frame_tick(tick_f)
    );

    task automatic wait_pixel(input int x, input int y);
        bit found = 0;
        for (int i = 0; i < FT + 4 && !found; i++) begin
            @(negedge clk);
            if (((cyc - 2) % FT) == (y * HT + x)) found = 1;
        end
        if (!found) begin
            failures++;
            $display("FAIL wait_pixel (%0d,%0d) never reached", x, y);
        end
    endtask

    task automatic wait_tick();
        bit found = 0;
        for (int i = 0; i < 2 * FT && !found; i++) begin
            @(negedge clk);
            if (tick_s === 1'b1) found = 1;
        end
        if (!found) begin
            failures++;
            $display("FAIL wait_tick no frame_tick within %0d clk", 2 * FT);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({hsync_s, vsync_s, tick_s, rgb_s} !== 15'h6000) begin
            failures++;
            $display("FAIL reset_small hs=%b vs=%b tick=%b rgb=%h expected 1 1 0 000", hsync_s, vsync_s, tick_s, rgb_s);
        end
        checks++;
        if ({hsync_f, vsync_f, tick_f, rgb_f} !== 15'h6000) begin
            failures++;
            $display("FAIL reset_full hs=%b vs=%b tick=%b rgb=%h expected 1 1 0 000", hsync_f, vsync_f, tick_f, rgb_f);
        end
        reset = 1'b1;
    endtask

    task automatic test_hsync();
        int exp_fall[2]   = '{86, 658};
        int exp_width[2]  = '{8, 96};
        int exp_period[2] = '{96, 800};
        for (int d = 0; d < 2; d++) begin
            int t_fall = -1, t_rise = -1, t_fall2 = -1;
            for (int i = 0; i < 2000 && t_fall < 0; i++) begin
                @(negedge clk);
                if ((d == 0 ? hsync_s : hsync_f) === 1'b0) t_fall = cyc;
            end
            for (int i = 0; i < 2000 && t_rise < 0; i++) begin
                @(negedge clk);
                if ((d == 0 ? hsync_s : hsync_f) === 1'b1) t_rise = cyc;
            end
            for (int i = 0; i < 2000 && t_fall2 < 0; i++) begin
                @(negedge clk);
                if ((d == 0 ? hsync_s : hsync_f) === 1'b0) t_fall2 = cyc;
            end
            checks++;
            if (t_fall != exp_fall[d]) begin
                failures++;
                $display("FAIL hsync_fall dut%0d got=%0d expected=%0d", d, t_fall, exp_fall[d]);
            end
            checks++;
            if (t_rise - t_fall != exp_width[d]) begin
                failures++;
                $display("FAIL hsync_width dut%0d got=%0d expected=%0d", d, t_rise - t_fall, exp_width[d]);
            end
            checks++;
            if (t_fall2 - t_fall != exp_period[d]) begin
                failures++;
                $display("FAIL hsync_period dut%0d got=%0d expected=%0d", d, t_fall2 - t_fall, exp_period[d]);
            end
        end
    endtask

    task automatic test_frame_tick();
        int t_tick = -1, t_vfall = -1, t_vrise = -1, t_tick2 = -1;
        for (int i = 0; i < 2 * FT && t_tick < 0; i++) begin
            @(negedge clk);
            if (tick_s === 1'b1) t_tick = cyc;
        end
        checks++;
        if (t_tick != 60 * HT + 1) begin
            failures++;
            $display("FAIL first_tick got=%0d expected=%0d", t_tick, 60 * HT + 1);
        end
        @(negedge clk);
        checks++;
        if (tick_s !== 1'b0) begin
            failures++;
            $display("FAIL tick_width tick=%b one clk later, expected 0", tick_s);
        end
        for (int i = 0; i < 2 * FT && t_vfall < 0; i++) begin
            @(negedge clk);
            if (vsync_s === 1'b0) t_vfall = cyc;
        end
        for (int i = 0; i < 2 * FT && t_vrise < 0; i++) begin
            @(negedge clk);
            if (vsync_s === 1'b1) t_vrise = cyc;
        end
        checks++;
        if (t_vfall != 62 * HT + 2) begin
            failures++;
            $display("FAIL vsync_fall got=%0d expected=%0d", t_vfall, 62 * HT + 2);
        end
        checks++;
        if (t_vrise - t_vfall != 2 * HT) begin
            failures++;
            $display("FAIL vsync_width got=%0d expected=%0d", t_vrise - t_vfall, 2 * HT);
        end
        for (int i = 0; i < 2 * FT && t_tick2 < 0; i++) begin
            @(negedge clk);
            if (tick_s === 1'b1) t_tick2 = cyc;
        end
        checks++;
        if (t_tick2 - t_tick != FT) begin
            failures++;
            $display("FAIL tick_period got=%0d expected=%0d", t_tick2 - t_tick, FT);
        end
    endtask

    // All walls, sprite snapped at (30,30) from the values held since reset
    task automatic test_wall_sprite();
        int          px[10] = '{0, 85, 30, 29, 30, 35, 49, 50, 49, 10};
        int          py[10] = '{0, 10, 29, 30, 30, 35, 49, 49, 50, 61};
        logic [11:0] pe[10] = '{12'h00F, 12'h000, 12'h00F, 12'h00F, 12'hFF0,
                                12'hFF0, 12'hFF0, 12'h00F, 12'h00F, 12'h000};
        for (int i = 0; i < 10; i++) begin
            wait_pixel(px[i], py[i]);
            checks++;
            if (rgb_s !== pe[i]) begin
                failures++;
                $display("FAIL wall_sprite (%0d,%0d) rgb=%h expected=%h", px[i], py[i], rgb_s, pe[i]);
            end
        end
    endtask

    // Tile 33 road with dot, tile 34 wall with dot bit set, sprite at (60,40)
    task automatic test_dot();
        int          px[13] = '{40, 21, 20, 27, 28, 31, 32, 48, 28, 31, 28, 39, 65};
        int          py[13] = '{20, 21, 25, 28, 28, 28, 28, 28, 31, 31, 32, 39, 45};
        logic [11:0] pe[13] = '{12'h00F, 12'h000, GRID_RGB, 12'h000, 12'hFFF, 12'hFFF, 12'h000,
                                12'h00F, 12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'hFF0};
        tilemap[33] = 1'b1;
        dots[33]    = 1'b1;
        dots[34]    = 1'b1;
        player_x    = 10'd60;
        player_y    = 9'd40;
        wait_tick();
        for (int i = 0; i < 13; i++) begin
            wait_pixel(px[i], py[i]);
            checks++;
            if (rgb_s !== pe[i]) begin
                failures++;
                $display("FAIL dot (%0d,%0d) rgb=%h expected=%h", px[i], py[i], rgb_s, pe[i]);
            end
        end
    endtask

    task automatic test_snapshot();
        int          px[5] = '{50, 30, 50, 69, 70};
        int          py[5] = '{9, 25, 25, 25, 25};
        logic [11:0] pe[5] = '{12'h00F, 12'h000, 12'hFF0, 12'hFF0, 12'h00F};
        player_x = 10'd30;
        player_y = 9'd10;
        wait_tick();
        wait_pixel(0, 20);
        player_x = 10'd50;
        wait_pixel(30, 25);
        checks++;
        if (rgb_s !== 12'hFF0) begin
            failures++;
            $display("FAIL snap_hold (30,25) rgb=%h expected=%h", rgb_s, 12'hFF0);
        end
        wait_pixel(50, 25);
        checks++;
        if (rgb_s !== 12'h00F) begin
            failures++;
            $display("FAIL snap_hold (50,25) rgb=%h expected=%h", rgb_s, 12'h00F);
        end
        wait_tick();
        for (int i = 0; i < 5; i++) begin
            wait_pixel(px[i], py[i]);
            checks++;
            if (rgb_s !== pe[i]) begin
                failures++;
                $display("FAIL snap_new (%0d,%0d) rgb=%h expected=%h", px[i], py[i], rgb_s, pe[i]);
            end
        end
    endtask

    // All-road map: bottom-right clipping, no wrap to row/column 0, and the grid pixels
    task automatic test_corner();
        int          px[8] = '{75, 20, 25, 0, 70, 85, 5, 79};
        int          py[8] = '{5, 5, 25, 50, 50, 50, 55, 59};
        logic [11:0] pe[8] = '{12'h000, GRID_RGB, 12'h000, GRID_RGB, 12'hFF0, 12'h000, 12'h000, 12'hFF0};
        int          qx[3] = '{2, 12, 1};
        int          qy[3] = '{5, 5, 19};
        tilemap  = '1;
        dots     = '0;
        player_x = 10'd70;
        player_y = 9'd50;
        wait_tick();
        for (int i = 0; i < 8; i++) begin
            wait_pixel(px[i], py[i]);
            checks++;
            if (rgb_s !== pe[i]) begin
                failures++;
                $display("FAIL corner (%0d,%0d) rgb=%h expected=%h", px[i], py[i], rgb_s, pe[i]);
            end
        end
        player_x = 10'd1010;
        player_y = 9'd0;
        wait_tick();
        for (int i = 0; i < 3; i++) begin
            wait_pixel(qx[i], qy[i]);
            checks++;
            if (rgb_s !== 12'h000) begin
                failures++;
                $display("FAIL no_wrap (%0d,%0d) rgb=%h expected=%h", qx[i], qy[i], rgb_s, 12'h000);
            end
        end
    endtask

    // Asynchronous reset mid-frame clears outputs at once and restarts the raster
    task automatic test_reset_restart();
        int t_fall = -1;
        tilemap = '0;
        wait_pixel(10, 10);
        checks++;
        if (rgb_s !== 12'h00F) begin
            failures++;
            $display("FAIL pre_reset rgb=%h expected=%h", rgb_s, 12'h00F);
        end
        #5 reset = 1'b0;
        #1;
        checks++;
        if ({hsync_s, vsync_s, tick_s, rgb_s} !== 15'h6000) begin
            failures++;
            $display("FAIL async_reset hs=%b vs=%b tick=%b rgb=%h expected 1 1 0 000", hsync_s, vsync_s, tick_s, rgb_s);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 400 && t_fall < 0; i++) begin
            @(negedge clk);
            if (hsync_s === 1'b0) t_fall = cyc;
        end
        checks++;
        if (t_fall != 86) begin
            failures++;
            $display("FAIL restart_hsync_fall got=%0d expected=%0d", t_fall, 86);
        end
    endtask

    initial begin
        reset    = 1'b0;
        tilemap  = '0;
        dots     = '0;
        player_x = 10'd30;
        player_y = 9'd30;
        test_reset();
        test_hsync();
        test_frame_tick();
        test_wall_sprite();
        test_dot();
        test_snapshot();
        test_corner();
        test_reset_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
